// File: rtl/result_collector.sv
// Collects per-unit results of one job and streams them out in index order.
// Optional watchdog: define RESULT_COLLECTOR_TIMEOUT_EN.
module result_collector #(
    parameter  int WIDTH          = 16,
    parameter  int NUM_UNITS      = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDXW           = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [NUM_UNITS-1:0]            active_units,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0] result_array,
    input  logic [NUM_UNITS-1:0]            ready_array,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [IDXW-1:0]                 out_index,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_UNITS-1:0]              mask_q, mask_d;
    logic [NUM_UNITS-1:0]              cap_q, cap_d;
    logic [NUM_UNITS-1:0]              pend_q, pend_d;
    logic [NUM_UNITS-1:0][WIDTH-1:0]   stored_q, stored_d;
    logic                              valid_q, valid_d;
    logic [WIDTH-1:0]                  data_q, data_d;
    logic [IDXW-1:0]                   index_q, index_d;
    logic                              last_q, last_d;
    logic                              done_q, done_d;
    logic [IDXW-1:0]                   nxt_idx;

`ifdef RESULT_COLLECTOR_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;
`endif

    function automatic logic [IDXW-1:0] lowest(input logic [NUM_UNITS-1:0] v);
        lowest = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDXW'(i);
        end
    endfunction

    function automatic logic single(input logic [NUM_UNITS-1:0] v);
        single = (v != '0) && ((v & (v - NUM_UNITS'(1))) == '0);
    endfunction

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cap_d    = cap_q;
        pend_d   = pend_q;
        stored_d = stored_q;
        valid_d  = valid_q;
        data_d   = data_q;
        index_d  = index_q;
        last_d   = last_q;
        done_d   = 1'b0;
        nxt_idx  = '0;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (active_units != '0) begin
                        mask_d  = active_units;
                        cap_d   = '0;
                        state_d = COLLECT;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cap_q == mask_q) begin
                    nxt_idx = lowest(cap_q);
                    state_d = DRAIN;
                    pend_d  = cap_q;
                    valid_d = 1'b1;
                    index_d = nxt_idx;
                    data_d  = stored_q[nxt_idx];
                    last_d  = single(cap_q);
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
                end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    // first ready per slot wins; later pulses are ignored
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        if (mask_q[i] && ready_array[i] && !cap_q[i]) begin
                            cap_d[i]    = 1'b1;
                            stored_d[i] = result_array[i];
                        end
                    end
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
                    cnt_d = cnt_q + CNTW'(1);
`endif
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pend_d = pend_q & ~(NUM_UNITS'(1) << index_q);
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        nxt_idx = lowest(pend_d);
                        index_d = nxt_idx;
                        data_d  = stored_q[nxt_idx];
                        last_d  = single(pend_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            cap_q    <= '0;
            pend_q   <= '0;
            stored_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            pend_q   <= pend_d;
            stored_q <= stored_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            index_q  <= index_d;
            last_q   <= last_d;
            done_q   <= done_d;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
    assign timeout   = to_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
